// File: rtl/comp_unit_ctrl.sv
// Sequencer for a multiply-accumulate comp_unit: runs k_len fetch/multiply/add terms, then one output cycle.
// Optional abort input is enabled with `define COMP_UNIT_CTRL_ABORT_EN.
module comp_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned ADD_CYCLES  = 7,
    parameter int unsigned K_WIDTH     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [K_WIDTH-1:0] k_len,
    input  logic               op_valid,
    input  logic               overflow,
`ifdef COMP_UNIT_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               ready,
    output logic               op_req,
    output logic               comp_rst,
    output logic               mult_en,
    output logic               add_en,
    output logic               out_en,
    output logic [K_WIDTH-1:0] term_idx,
    output logic               done,
    output logic               ovf_flag
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > ADD_CYCLES) ? MULT_CYCLES : ADD_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] ADD_LAST  = CW'(ADD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        MULT,
        ADD,
        OUT
    } state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [K_WIDTH-1:0] k_reg, k_nx;
    logic [K_WIDTH-1:0] term_nx;
    logic               ovf_nx;
    logic               abort_hit;

    logic ready_nx, op_req_nx, comp_rst_nx, mult_en_nx, add_en_nx, out_en_nx, done_nx;

`ifdef COMP_UNIT_CTRL_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            k_reg    <= '0;
            term_idx <= '0;
            ovf_flag <= 1'b0;
            ready    <= 1'b1;
            op_req   <= 1'b0;
            comp_rst <= 1'b1;
            mult_en  <= 1'b0;
            add_en   <= 1'b0;
            out_en   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            k_reg    <= k_nx;
            term_idx <= term_nx;
            ovf_flag <= ovf_nx;
            ready    <= ready_nx;
            op_req   <= op_req_nx;
            comp_rst <= comp_rst_nx;
            mult_en  <= mult_en_nx;
            add_en   <= add_en_nx;
            out_en   <= out_en_nx;
            done     <= done_nx;
        end
    end

    // cnt counts elapsed cycles within MULT/ADD and is zero on every phase entry
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        k_nx     = k_reg;
        term_nx  = term_idx;
        ovf_nx   = ovf_flag;
        unique case (state)
            IDLE: begin
                if (start && (k_len != '0)) begin
                    state_nx = CLEAR;
                    k_nx     = k_len;
                    term_nx  = '0;
                    ovf_nx   = 1'b0;
                end
            end
            CLEAR: state_nx = FETCH;
            FETCH: begin
                if (op_valid) state_nx = MULT;
            end
            MULT: begin
                if (cnt == MULT_LAST) state_nx = ADD;
                else                  cnt_nx   = cnt + 1'b1;
            end
            ADD: begin
                if (cnt == ADD_LAST) begin
                    if (term_idx != k_reg - K_WIDTH'(1)) begin
                        term_nx  = term_idx + K_WIDTH'(1);
                        state_nx = FETCH;
                    end else begin
                        state_nx = OUT;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (((state == MULT) || (state == ADD) || (state == OUT)) && overflow)
            ovf_nx = 1'b1;
        if (abort_hit) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            term_nx  = term_idx;
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        ready_nx    = (state_nx == IDLE);
        op_req_nx   = (state_nx == FETCH);
        comp_rst_nx = (state_nx == CLEAR) || abort_hit;
        mult_en_nx  = (state_nx == MULT);
        add_en_nx   = (state_nx == ADD);
        out_en_nx   = (state_nx == OUT);
        done_nx     = ((state == OUT) && !abort_hit) ||
                      ((state == IDLE) && start && (k_len == '0));
    end

endmodule

// File: doc/comp_unit_ctrl.md
COMP_UNIT_CTRL -- requirements
Module: comp_unit_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  MULT_CYCLES  5  cycles mult_en is held per term
  ADD_CYCLES   7  cycles add_en is held per term
  K_WIDTH      4  width of term count k_len
REQ-002 Ports (name  direction  width  meaning) SHALL be, clock and reset first:
  clk       in   1        single clock, rising edge
  reset     in   1        synchronous, active-high
  start     in   1        begin dot-product sequence; sampled only in IDLE
  k_len     in   K_WIDTH  number of multiply-accumulate terms; captured with start
  op_valid  in   1        operand pair on Ain/Bin is valid
  overflow  in   1        overflow from comp_unit
  ready     out  1        high in IDLE
  op_req    out  1        request next operand pair
  comp_rst  out  1        clears the comp_unit accumulator
  mult_en   out  1        comp_unit multiply enable
  add_en    out  1        comp_unit add enable
  out_en    out  1        comp_unit output enable
  term_idx  out  K_WIDTH  index of the current term, 0-based
  done      out  1        one-cycle completion pulse
  ovf_flag  out  1        sticky overflow for the current sequence

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, FETCH, MULT, ADD, OUT; all outputs SHALL be registered Moore outputs.
REQ-004 IDLE with start=1 and k_len>0: capture k_len, clear term_idx and ovf_flag, go to CLEAR.
REQ-005 IDLE with start=1 and k_len=0: stay in IDLE and pulse done on the next cycle; no enable, op_req or comp_rst is asserted.
REQ-006 CLEAR lasts exactly 1 cycle with comp_rst=1, then goes to FETCH.
REQ-007 FETCH holds op_req=1; op_valid=1 sampled in FETCH moves to MULT next cycle; otherwise FETCH repeats with no timeout.
REQ-008 MULT holds mult_en=1 for exactly MULT_CYCLES cycles, then goes to ADD.
REQ-009 ADD holds add_en=1 for exactly ADD_CYCLES cycles, then:
  - if term_idx < k_len-1: increment term_idx and go to FETCH;
  - otherwise go to OUT.
REQ-010 OUT holds out_en=1 for exactly 1 cycle, then goes to IDLE with done=1 for that first IDLE cycle.
REQ-011 At most one of comp_rst, mult_en, add_en, out_en SHALL be high in any cycle.
REQ-012 Per-term latency with op_valid held high SHALL be 1+MULT_CYCLES+ADD_CYCLES cycles (13 at defaults).
REQ-013 ovf_flag SHALL set when overflow=1 in MULT, ADD or OUT, hold until the next accepted start, and remain readable in IDLE.
REQ-014 start asserted outside IDLE SHALL be ignored; k_len changes after capture SHALL have no effect.
REQ-015 Phase counters SHALL be sized for the parameters and SHALL NOT wrap within a phase.

Reset
REQ-016 reset=1 at a clock edge SHALL force IDLE, including mid-sequence; the next cycle SHALL have ready=1, comp_rst=1, all other outputs 0 and term_idx=0.
REQ-017 The in-progress sequence SHALL be discarded on reset with no done pulse; reset SHALL take priority over start and abort.

Configuration
REQ-018 Macro COMP_UNIT_CTRL_ABORT_EN defined: add input port abort (1 bit).
  - abort=1 in any non-IDLE state returns to IDLE next cycle, with comp_rst=1 for that cycle.
  - No done pulse is produced; ovf_flag is held.
REQ-019 Macro COMP_UNIT_CTRL_ABORT_EN undefined: the abort port SHALL NOT exist, and the sequence is interruptible only by reset.

Verification (cycle 0 = edge sampling start; defaults; op_valid=1 unless stated)
REQ-020 k_len=1 -> comp_rst at cycle 1, op_req at 2, mult_en 3-7, add_en 8-14, out_en 15, done 16, ready 16.
REQ-021 k_len=3 -> term_idx steps 0/1/2 at cycles 2/15/28, out_en at 41, done at 42, exactly 3 mult_en bursts of 5 cycles each.
REQ-022 k_len=0 -> done at cycle 1; comp_rst, op_req, mult_en, add_en and out_en stay 0 throughout.
REQ-023 k_len=1, op_valid low for cycles 2-5 and high at 6 -> op_req 2-6, mult_en 7-11, done 20.
REQ-024 k_len=2, overflow pulsed at cycle 10 -> ovf_flag 1 from cycle 11 through done and IDLE; the next start clears it.
REQ-025 k_len=2, reset at cycle 9 (ADD phase) -> cycle 10 IDLE, comp_rst=1, no done; with COMP_UNIT_CTRL_ABORT_EN defined, abort at cycle 9 gives the same response.
